ham_secded_dec_pipe: RTL and testbench

//  Parametrised, pipelined Hamming decoder. It is the next generation of the 14/10 decoder.

---
 rtl/ham_secded_dec_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_ham_secded_dec_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_secded_dec_pipe.sv
// ham_secded_dec_pipe
//   Two-stage valid/ready pipelined Hamming decoder with single-error correction.
//   It can also detect double errors (SECDED), and it keeps saturating error statistics.
//   Optional feature macro: SECDED_EN.
//     - Defined: in_code carries an extra overall even-parity bit, and double errors are flagged.
//     - Undefined: SEC only; for DATA_W=10 this is the legacy 14/10 layout.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset; flushes both stages and clears outputs/counters
//   in_valid    in_code is valid
//   in_ready    decoder accepts in_code this cycle (combinational)
//   in_code     received codeword [CW_W-1:0]; bit i holds Hamming position i+1
//   out_valid   out_* fields are valid
//   out_ready   consumer accepts out_* this cycle
//   out_data    corrected payload [DATA_W-1:0]
//   out_syn     raw syndrome [P-1:0]
//   out_corr    a single error was corrected (or the overall parity bit was wrong)
//   out_uncorr  uncorrectable error; out_data is passed through uncorrected
//   cnt_clr     synchronous clear of both counters, wins over an increment
//   corr_cnt    saturating count of corrected words
//   uncorr_cnt  saturating count of uncorrectable words
module ham_secded_dec_pipe #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8,
  // Smallest p with 2^p >= DATA_W+p+1. The inner clog2 is a lower bound for p,
  // and the true p is either that bound or one more.
  localparam int P = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int N = DATA_W + P,
`ifdef SECDED_EN
  localparam int CW_W = N + 1
`else
  localparam int CW_W = N
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syn,
  output logic              out_corr,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [P:0]       N_EXT   = (P + 1)'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

  // Syndrome: XOR of the position numbers of every set bit. Parity bits are
  // included, so a clean word yields zero and a single flip yields its position.
  function automatic logic [P-1:0] calc_syn(input logic [N-1:0] code);
    logic [P-1:0] s;
    s = {P{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (code[i]) begin
        s = s ^ P'(i + 1);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Gathers the payload from the non-power-of-two positions in ascending order.
  // Each data bit is shifted in at the MSB, so the first one found ends at bit 0.
  function automatic logic [DATA_W-1:0] extract_data(input logic [N-1:0] code);
    logic [DATA_W-1:0] d;
    d = {DATA_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        d = {code[i], d[DATA_W-1:1]};
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // Stage 1 state
  logic         v1;
  logic [N-1:0] code1;
  logic [P-1:0] syn1;
`ifdef SECDED_EN
  logic         g1;
`endif

  // Handshake and stage-enable terms
  logic s1_load;
  logic s2_load;
  logic out_hs;

  // Stage 2 next-state values
  logic [N-1:0] fixed_code;
  logic         flip;
  logic         corr_nxt;
  logic         uncorr_nxt;
  logic         syn_in_range;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !v1 || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = out_valid && out_ready;

  // Stage 1: register the received word together with its syndrome and overall parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      code1 <= {N{1'b0}};
      syn1  <= {P{1'b0}};
`ifdef SECDED_EN
      g1    <= 1'b0;
`endif
    end else if (s1_load) begin
      v1 <= in_valid;
      if (in_valid) begin
        code1 <= in_code[N-1:0];
        syn1  <= calc_syn(in_code[N-1:0]);
`ifdef SECDED_EN
        g1    <= ^in_code;
`endif
      end
    end
  end

  assign syn_in_range = ({1'b0, syn1} <= N_EXT);

  // Error classification: decide whether to flip, and whether to flag corr or uncorr
  always_comb begin
    flip       = 1'b0;
    corr_nxt   = 1'b0;
    uncorr_nxt = 1'b0;
`ifdef SECDED_EN
    if (syn1 == {P{1'b0}}) begin
      // A zero syndrome with odd overall parity means only the extra parity bit flipped.
      corr_nxt = g1;
    end else if (g1 && syn_in_range) begin
      flip     = 1'b1;
      corr_nxt = 1'b1;
    end else begin
      uncorr_nxt = 1'b1;
    end
`else
    if (syn1 == {P{1'b0}}) begin
      corr_nxt = 1'b0;
    end else if (syn_in_range) begin
      flip     = 1'b1;
      corr_nxt = 1'b1;
    end else begin
      // The syndrome points past the last position, so no single flip explains it.
      uncorr_nxt = 1'b1;
    end
`endif
  end

  // Correction: invert the bit that the syndrome points at, when allowed
  always_comb begin
    fixed_code = code1;
    for (int i = 0; i < N; i++) begin
      if (flip && (syn1 == P'(i + 1))) begin
        fixed_code[i] = ~code1[i];
      end else begin
        fixed_code[i] = code1[i];
      end
    end
  end

  // Stage 2: register corrected outputs; hold them while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= {DATA_W{1'b0}};
      out_syn    <= {P{1'b0}};
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (s2_load) begin
      out_valid <= v1;
      if (v1) begin
        out_data   <= extract_data(fixed_code);
        out_syn    <= syn1;
        out_corr   <= corr_nxt;
        out_uncorr <= uncorr_nxt;
      end
    end
  end

  // Error statistics: count on output handshake, saturate, clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= {CNT_W{1'b0}};
      uncorr_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      corr_cnt   <= {CNT_W{1'b0}};
      uncorr_cnt <= {CNT_W{1'b0}};
    end else begin
      if (out_hs && out_corr && (corr_cnt != CNT_MAX)) begin
        corr_cnt <= corr_cnt + CNT_ONE;
      end
      if (out_hs && out_uncorr && (uncorr_cnt != CNT_MAX)) begin
        uncorr_cnt <= uncorr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ham_secded_dec_pipe.sv
// Scoreboard bench for ham_secded_dec_pipe at DATA_W=10, CNT_W=8.
// Works with or without SECDED_EN, provided the macro is set the same way as for the RTL.
module tb_ham_secded_dec_pipe;

  localparam int DATA_W = 10;
  localparam int CNT_W  = 8;
  localparam int P      = 4;
  localparam int N      = 14;
`ifdef SECDED_EN
  localparam int CW_W = N + 1;
`else
  localparam int CW_W = N;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [P-1:0]      syn;
    logic              corr;
    logic              uncorr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syn;
  logic              out_corr;
  logic              out_uncorr;
  logic              cnt_clr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   m_corr = 0;
  int   m_uncorr = 0;
  logic stall_hold = 1'b0;
  logic [DATA_W+P+1:0] held;
  logic rnd_done;

  ham_secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syn(out_syn),
    .out_corr(out_corr), .out_uncorr(out_uncorr),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder: place the data, then set each parity bit to the syndrome bit it owns.
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    logic [P-1:0] s;
    int j;
    c = '0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    s = '0;
    for (int i = 0; i < N; i++) if (c[i]) s = s ^ P'(i + 1);
    for (int k = 0; k < P; k++) c[(1 << k) - 1] = s[k];
`ifdef SECDED_EN
    c[N] = ^c[N-1:0];
`endif
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [N-1:0] c);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // Flip mask from up to three bit indices (-1 = unused).
  function automatic logic [CW_W-1:0] fm(input int a, input int b, input int c);
    logic [CW_W-1:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  // Expected decode of encode(d)^m. Syndrome is linear, so it depends only on m.
  function automatic exp_t model(input logic [DATA_W-1:0] d, input logic [CW_W-1:0] m);
    exp_t e;
    logic [CW_W-1:0] cc;
    logic [N-1:0] fx;
    logic [P-1:0] s;
    logic g;
    int idx;
    cc = encode(d) ^ m;
    s = '0;
    for (int i = 0; i < N; i++) if (m[i]) s = s ^ P'(i + 1);
    g = ^m;
    fx = cc[N-1:0];
    e.syn = s;
    e.corr = 1'b0;
    e.uncorr = 1'b0;
    idx = int'(s) - 1;
`ifdef SECDED_EN
    if (s == '0) e.corr = g;
    else if (g && (int'(s) <= N)) begin e.corr = 1'b1; fx[idx] = ~fx[idx]; end
    else e.uncorr = 1'b1;
`else
    g = 1'b0;
    if (s == '0) e.corr = g;
    else if (int'(s) <= N) begin e.corr = 1'b1; fx[idx] = ~fx[idx]; end
    else e.uncorr = 1'b1;
`endif
    e.data = ($countones(m) <= 1) ? d : extract(fx);
    return e;
  endfunction

  // Drive one word; it stays offered until accepted. in_valid is left high for back-to-back use.
  task automatic send_word(input logic [DATA_W-1:0] d, input logic [CW_W-1:0] m);
    logic acc;
    int n;
    in_code = encode(d) ^ m;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) sb_q.push_back(model(d, m));
    else check("send_timeout", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare, stall stability, counter model
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      m_corr = 0;
      m_uncorr = 0;
      stall_hold = 1'b0;
    end
    check("corr_cnt", corr_cnt, m_corr);
    check("uncorr_cnt", uncorr_cnt, m_uncorr);
    if (!rst) begin
      if (stall_hold && out_valid)
        check("stable", {out_data, out_syn, out_corr, out_uncorr}, held);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("data", out_data, e.data);
          check("syn", out_syn, e.syn);
          check("corr", out_corr, e.corr);
          check("uncorr", out_uncorr, e.uncorr);
          if (!cnt_clr) begin
            if (e.corr && m_corr < 255) m_corr++;
            if (e.uncorr && m_uncorr < 255) m_uncorr++;
          end
        end
      end
      if (cnt_clr) begin
        m_corr = 0;
        m_uncorr = 0;
      end
      stall_hold = out_valid && !out_ready;
      held = {out_data, out_syn, out_corr, out_uncorr};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // 1: back-to-back clean words, 2-cycle latency
    send_word(10'h2A5, '0);
    check("t1_lat0", out_valid, 0);
    send_word(10'h15A, '0);
    in_valid = 1'b0;
    check("t1_lat_valid", out_valid, 1);
    check("t1_lat_data", out_data, 10'h2A5);
    @(posedge clk);
    #1;
    check("t1_next_data", out_data, 10'h15A);
    drain();

    // 2: single error at index 5 (position 6)
    send_word(10'h2A5, fm(5, -1, -1));
    in_valid = 1'b0;
    drain();
    check("t2_corr_cnt", corr_cnt, 1);

    // 3: double error at Hamming positions 2 and 9 (indices 1 and 8), syndrome 11
    send_word(10'h2A5, fm(1, 8, -1));
    in_valid = 1'b0;
    drain();
`ifdef SECDED_EN
    check("t3_uncorr_cnt", uncorr_cnt, 1);
`else
    check("t3_corr_cnt", corr_cnt, 2);
`endif

    // Boundary words: syndrome 15 (> N), two triples, parity-bit flips
    send_word(10'h0F3, fm(0, 13, -1));
    send_word(10'h3C1, fm(0, 1, 11));
    send_word(10'h155, fm(0, 1, 3));
    send_word(10'h3FF, fm(13, -1, -1));
    send_word(10'h000, fm(0, -1, -1));
`ifdef SECDED_EN
    send_word(10'h1A7, fm(N, -1, -1));
    send_word(10'h1A7, fm(N, 4, -1));
`endif
    in_valid = 1'b0;
    drain();

    // 4: output stall with in_valid held high
    out_ready = 1'b0;
    send_word(10'h101, '0);
    send_word(10'h202, fm(2, -1, -1));
    in_code = encode(10'h303);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_word(10'h303, '0);
    send_word(10'h004, fm(9, -1, -1));
    send_word(10'h055, '0);
    in_valid = 1'b0;
    drain();

    // Random in_valid gaps and out_ready toggling: order and count must be preserved
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 1) == 0) send_word(DATA_W'($urandom), '0);
          else send_word(DATA_W'($urandom), fm($urandom_range(0, CW_W - 1), -1, -1));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 1) == 1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // 5: saturate corr_cnt, then clear together with a corrected handshake
    for (int k = 0; k < 300; k++)
      send_word(DATA_W'($urandom), fm($urandom_range(0, N - 1), -1, -1));
    in_valid = 1'b0;
    drain();
    check("t5_corr_sat", corr_cnt, 255);
    out_ready = 1'b0;
    send_word(10'h0F0, fm(3, -1, -1));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_clr_setup", out_valid, 1);
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("t5_corr_clr", corr_cnt, 0);
    drain();

    // 6: reset with both stages full
    send_word(10'h2A5, fm(7, -1, -1));
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send_word(10'h0AA, '0);
    send_word(10'h0BB, fm(1, 8, -1));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_corr_cnt", corr_cnt, 0);
    check("t6_uncorr_cnt", uncorr_cnt, 0);
    check("t6_out_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_in_ready", in_ready, 1);
    send_word(10'h111, '0);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
